// File: rtl/median_driver.sv
// Initiator for the MEDIAN pixel protocol: reads 9-pixel windows from memory,
// streams them to MEDIAN, and writes each returned median back to memory.
module median_driver #(
    parameter int SIZE = 8,
    parameter int AW   = 10,
    parameter int TMO  = 60
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            START,
    input  logic [AW-1:0]   SRC,
    input  logic [AW-1:0]   DST,
    input  logic [7:0]      N,
    output logic            BUSY,
    output logic            DONE,
    output logic            ERR,
    output logic [AW-1:0]   ADDR,
    output logic            RE,
    output logic            WE,
    output logic [SIZE-1:0] WDATA,
    input  logic [SIZE-1:0] RDATA,
    output logic [SIZE-1:0] PIX_O,
    output logic            PIX_V,
    input  logic [SIZE-1:0] MED_I,
    input  logic            MED_V
);
    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_GAP, S_WAIT, S_WR, S_FIN} state_t;

    state_t        state;
    logic [AW-1:0] src_q, dst_q;
    logic [7:0]    n_q, k;
    logic [3:0]    i;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    k_next;

    // First address of window kk: 9*kk formed in 12 bits, then added modulo 2^AW.
    function automatic logic [AW-1:0] win_base(input logic [AW-1:0] base, input logic [7:0] kk);
        logic [11:0] nine;
        nine = {1'b0, kk, 3'b000} + {4'b0000, kk};
        return base + AW'(nine);
    endfunction

    assign k_next = k + 8'd1;
    assign PIX_O  = RDATA;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= S_IDLE;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
            RE      <= 1'b0;
            WE      <= 1'b0;
            PIX_V   <= 1'b0;
            ADDR    <= '0;
            WDATA   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            n_q     <= '0;
            k       <= '0;
            i       <= '0;
            tmo_cnt <= '0;
        end else begin
            RE    <= 1'b0;
            WE    <= 1'b0;
            DONE  <= 1'b0;
            // MEDIAN sees each pixel the cycle after its read, so DSI tracks RE by one.
            PIX_V <= RE;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        src_q <= SRC;
                        dst_q <= DST;
                        n_q   <= N;
                        ERR   <= 1'b0;
                        k     <= '0;
                        i     <= '0;
                        if (N == 8'd0) begin
                            DONE  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            BUSY  <= 1'b1;
                            RE    <= 1'b1;
                            ADDR  <= SRC;
                            state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (i == 4'd8) begin
                        state <= S_GAP;
                    end else begin
                        i    <= i + 4'd1;
                        RE   <= 1'b1;
                        ADDR <= ADDR + AW'(1);
                    end
                end
                S_GAP: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (MED_V) begin
                        WDATA <= MED_I;
                        WE    <= 1'b1;
                        ADDR  <= dst_q + AW'(k);
                        state <= S_WR;
                    end else if (tmo_cnt == TW'(TMO - 1)) begin
                        // Result lost: flag it and abandon the remaining windows.
                        ERR   <= 1'b1;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= S_FIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_WR: begin
                    k <= k_next;
                    if (k_next == n_q) begin
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= S_FIN;
                    end else begin
                        i     <= '0;
                        RE    <= 1'b1;
                        ADDR  <= win_base(src_q, k_next);
                        state <= S_RD;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_median_driver.sv
// Randomised and directed bench for median_driver with a memory model,
// a behavioural MEDIAN stub and a command-level reference model.
module tb_median_driver;
    localparam int AW  = 10;
    localparam int TMO = 60;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          START = 1'b0;
    logic [AW-1:0] SRC = '0, DST = '0;
    logic [7:0]    N = '0;
    logic          BUSY, DONE, ERR, RE, WE, PIX_V, MED_V;
    logic [AW-1:0] ADDR;
    logic [7:0]    WDATA, RDATA, PIX_O, MED_I;

    median_driver #(.SIZE(8), .AW(AW), .TMO(TMO)) dut (
        .CLK(CLK), .nRST(nRST), .START(START), .SRC(SRC), .DST(DST), .N(N),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ADDR(ADDR), .RE(RE), .WE(WE),
        .WDATA(WDATA), .RDATA(RDATA), .PIX_O(PIX_O), .PIX_V(PIX_V),
        .MED_I(MED_I), .MED_V(MED_V)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // median of nine by rank counting
    function automatic logic [7:0] med9(input logic [7:0] w [9]);
        int lt, le;
        for (int x = 0; x < 9; x++) begin
            lt = 0; le = 0;
            for (int y = 0; y < 9; y++) begin
                if (w[y] < w[x])  lt++;
                if (w[y] <= w[x]) le++;
            end
            if (lt <= 4 && le >= 5) return w[x];
        end
        return 8'h00;
    endfunction

    // memory: registered read, writes only logged
    logic [7:0] mem [1024];
    always @(posedge CLK) if (RE) RDATA <= mem[ADDR];

    // MEDIAN stub: collects a window, answers lat_v cycles after DSI falls
    int         lat_v = 41;
    bit         stuck_v = 1'b0;
    bit         noise_v = 1'b0;
    logic       med_v_q;
    logic [7:0] med_i_q;
    logic [7:0] win [$];
    logic [7:0] stub_a [9];
    logic [7:0] stub_val;
    int         stub_d;
    bit         pending;
    logic       noise_now;

    assign noise_now = noise_v && (RE || PIX_V || WE || DONE);
    assign MED_V = noise_now ? 1'b1 : med_v_q;
    assign MED_I = noise_now ? 8'hEE : med_i_q;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            win.delete();
            pending = 1'b0;
            stub_d  = 0;
            med_v_q <= 1'b0;
            med_i_q <= 8'h00;
        end else begin
            med_v_q <= 1'b0;
            if (pending) begin
                if (stub_d <= 1) begin
                    med_v_q <= 1'b1;
                    med_i_q <= stub_val;
                    pending = 1'b0;
                end else stub_d--;
            end
            if (PIX_V) win.push_back(PIX_O);
            else if (win.size() == 9) begin
                foreach (stub_a[j]) stub_a[j] = win[j];
                stub_val = med9(stub_a);
                win.delete();
                if (!stuck_v) begin
                    pending = 1'b1;
                    stub_d  = lat_v;
                end
            end else win.delete();
        end
    end

    // monitor
    logic [17:0] wr_log [$];
    logic [7:0]  pix_log [$];
    int re_cnt = 0, we_cnt = 0, both_cnt = 0;
    always @(negedge CLK) begin
        if (WE) begin
            wr_log.push_back({ADDR, WDATA});
            we_cnt++;
        end
        if (RE) re_cnt++;
        if (RE && WE) both_cnt++;
        if (PIX_V) pix_log.push_back(PIX_O);
    end

    task automatic run(input logic [AW-1:0] src, input logic [AW-1:0] dst, input logic [7:0] n,
                       input int lat, input bit stuck, input bit poke, input string tag);
        int nw, exp_cyc, cyc, re0, we0, both0, wr0, px0, bad;
        bit err_exp;
        logic [7:0]    w [9];
        logic [7:0]    exp_pix [$];
        logic [17:0]   exp_wr [$];
        logic [AW-1:0] a;
        lat_v   = lat;
        stuck_v = stuck;
        nw      = (stuck && n != 0) ? 1 : int'(n);
        for (int k = 0; k < nw; k++) begin
            for (int j = 0; j < 9; j++) begin
                w[j] = mem[(int'(src) + 9 * k + j) % 1024];
                exp_pix.push_back(w[j]);
            end
            a = AW'(int'(dst) + k);
            if (!stuck) exp_wr.push_back({a, med9(w)});
        end
        exp_cyc = (n == 0) ? 1 : (stuck ? TMO + 11 : int'(n) * (13 + lat) + 1);
        err_exp = stuck && n != 0;
        re0 = re_cnt; we0 = we_cnt; both0 = both_cnt;
        wr0 = wr_log.size(); px0 = pix_log.size();

        @(posedge CLK); #1;
        START = 1'b1; SRC = src; DST = dst; N = n;
        @(posedge CLK); #1;
        START = 1'b0;
        cyc = 0;
        while (cyc < 5000) begin
            cyc++;
            @(negedge CLK);
            if (cyc == 1) begin
                chk({tag, "_err_clr"}, ERR, 0);
                chk({tag, "_busy"}, BUSY, n != 0);
            end
            if (poke && cyc == 4) begin
                START = 1'b1; SRC = src ^ 10'h155; DST = dst ^ 10'h0AA; N = n + 8'd3;
            end
            if (poke && cyc == 5) START = 1'b0;
            if (DONE) break;
            @(posedge CLK);
        end
        chk({tag, "_done_cyc"}, cyc, exp_cyc);
        chk({tag, "_busy_fin"}, BUSY, 0);
        chk({tag, "_err"}, ERR, err_exp);
        repeat (3) @(negedge CLK);
        chk({tag, "_done_pulse"}, DONE, 0);
        chk({tag, "_err_hold"}, ERR, err_exp);
        chk({tag, "_nwr"}, wr_log.size() - wr0, exp_wr.size());
        bad = 0;
        for (int x = 0; x < exp_wr.size() && wr0 + x < wr_log.size(); x++)
            if (wr_log[wr0 + x] !== exp_wr[x]) bad++;
        chk({tag, "_wr_bad"}, bad, 0);
        chk({tag, "_npix"}, pix_log.size() - px0, exp_pix.size());
        bad = 0;
        for (int x = 0; x < exp_pix.size() && px0 + x < pix_log.size(); x++)
            if (pix_log[px0 + x] !== exp_pix[x]) bad++;
        chk({tag, "_pix_bad"}, bad, 0);
        chk({tag, "_re_cnt"}, re_cnt - re0, 9 * nw);
        chk({tag, "_we_cnt"}, we_cnt - we0, exp_wr.size());
        chk({tag, "_re_we"}, both_cnt - both0, 0);
    endtask

    logic [7:0] t_win0 [9] = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
    logic [7:0] t_win1 [9] = '{250, 200, 10, 200, 255, 200, 3, 200, 201};
    logic [7:0] t_win2 [9] = '{0, 0, 0, 0, 0, 7, 9, 100, 1};

    initial begin
        int wr0, lim;
        for (int x = 0; x < 1024; x++) mem[x] = 8'($urandom);
        for (int j = 0; j < 9; j++) begin
            mem[j]      = t_win0[j];
            mem[9 + j]  = t_win1[j];
            mem[18 + j] = t_win2[j];
        end

        repeat (3) @(negedge CLK);
        chk("rst_ctl", {BUSY, DONE, ERR, RE, WE, PIX_V}, 0);
        chk("rst_addr", ADDR, 0);
        chk("rst_wdata", WDATA, 0);
        nRST = 1'b1;
        repeat (2) @(negedge CLK);

        run(10'd0,   10'd100, 8'd1, 41, 1'b0, 1'b0, "t1");
        run(10'd0,   10'd100, 8'd3, 41, 1'b0, 1'b0, "t2");
        run(10'd5,   10'd100, 8'd0, 41, 1'b0, 1'b0, "t3");
        run(10'd0,   10'd120, 8'd2, 41, 1'b1, 1'b0, "t4");
        run(10'd0,   10'd130, 8'd1, 20, 1'b0, 1'b0, "t4b");
        noise_v = 1'b1;
        run(10'd0,   10'd140, 8'd1, 40, 1'b0, 1'b0, "t5");
        noise_v = 1'b0;

        // reset during the WAIT of the second window
        wr0 = wr_log.size();
        @(posedge CLK); #1;
        START = 1'b1; SRC = 10'd200; DST = 10'd700; N = 8'd4; lat_v = 41; stuck_v = 1'b0;
        @(posedge CLK); #1;
        START = 1'b0;
        lim = 0;
        while (wr_log.size() - wr0 < 1 && lim < 500) begin
            @(negedge CLK);
            lim++;
        end
        chk("t6_first_wr", wr_log.size() - wr0, 1);
        repeat (20) @(negedge CLK);
        chk("t6_in_wait", {BUSY, RE, PIX_V, WE}, 4'b1000);
        #1 nRST = 1'b0;
        #1;
        chk("t6_rst_ctl", {BUSY, DONE, ERR, RE, WE, PIX_V}, 0);
        chk("t6_rst_addr", ADDR, 0);
        chk("t6_rst_wdata", WDATA, 0);
        repeat (3) @(negedge CLK);
        nRST = 1'b1;
        repeat (150) @(negedge CLK);
        chk("t6_no_wr", wr_log.size() - wr0, 1);
        chk("t6_idle", BUSY, 0);
        run(10'd300, 10'd800, 8'd2, 10, 1'b0, 1'b0, "t6b");

        run(10'd27,   10'd150, 8'd3, 30, 1'b0, 1'b1, "t7");
        run(10'd1020, 10'd1022, 8'd2, 5, 1'b0, 1'b0, "wrap");

        for (int r = 0; r < 6; r++) begin
            noise_v = 1'($urandom);
            run(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                8'($urandom_range(0, 4)), $urandom_range(1, 55), 1'b0, 1'b0, "rnd");
        end
        noise_v = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
